// File: rtl/datapath_seq_pkg.sv
// Shared definitions for datapath_seq: opcodes, sequencer states and iteration count.
// The DIV opcode is only legal when DATAPATH_SEQ_DIV_EN is defined.
package datapath_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHRA = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_NEG  = 5'd8;
  localparam logic [4:0] OP_NOT  = 5'd9;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_Y,
    ST_EXEC,
    ST_ITER,
    ST_WRITE
  } state_t;

  // One multiplier/divider bit is resolved per ITER cycle.
  function automatic int iterCount(input int dataW);
    return dataW;
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Request, external-load, debug and status bundle between the control unit and datapath_seq.
interface datapath_seq_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic              start;
  logic [4:0]        opcode;
  logic [SEL_W-1:0]  ra_sel;
  logic [SEL_W-1:0]  rb_sel;
  logic [SEL_W-1:0]  rc_sel;
  logic              use_imm;
  logic [DATA_W-1:0] imm;
  logic              ext_wr_en;
  logic [SEL_W-1:0]  ext_wr_sel;
  logic [DATA_W-1:0] ext_wr_data;
  logic [SEL_W-1:0]  dbg_rd_sel;
  logic [DATA_W-1:0] dbg_rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, opcode, ra_sel, rb_sel, rc_sel, use_imm, imm,
    output ext_wr_en, ext_wr_sel, ext_wr_data, dbg_rd_sel,
    input  dbg_rd_data, busy, done, err, result, hi_out, lo_out
  );

  modport slave (
    input  start, opcode, ra_sel, rb_sel, rc_sel, use_imm, imm,
    input  ext_wr_en, ext_wr_sel, ext_wr_data, dbg_rd_sel,
    output dbg_rd_data, busy, done, err, result, hi_out, lo_out
  );
endinterface

// File: rtl/datapath_seq_iter_muldiv.sv
// iter_muldiv: shift-add unsigned multiplier, plus a restoring divider when DATAPATH_SEQ_DIV_EN
// is defined. Loaded by i_start, then resolves one bit per cycle for DATA_W cycles.
module iter_muldiv
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              i_start,
  input  logic              i_isDiv,
  input  logic [DATA_W-1:0] i_opA,
  input  logic [DATA_W-1:0] i_opB,
  output logic              o_last,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] ITER_N = CNT_W'(iterCount(DATA_W));

  logic [CNT_W-1:0]    r_count;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opB;
  logic [2*DATA_W-1:0] w_accNext;
  logic [DATA_W:0]     w_mulSum;

  // Multiply: {acc_hi + carry, multiplier} shifts right, adding the multiplicand on a set LSB.
  assign w_mulSum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opB} : '0);

`ifdef DATAPATH_SEQ_DIV_EN
  logic            r_isDiv;
  logic [DATA_W:0] w_divRem;
  logic [DATA_W:0] w_divTrial;

  // Divide: {remainder, quotient} shifts left; a borrow-free trial subtract sets the quotient bit.
  assign w_divRem   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_divTrial = w_divRem - {1'b0, r_opB};

  always_comb begin
    w_accNext = {w_mulSum, r_acc[DATA_W-1:1]};
    if (r_isDiv) begin
      if (w_divTrial[DATA_W]) begin
        w_accNext = {r_acc[2*DATA_W-2:0], 1'b0};
      end else begin
        w_accNext = {w_divTrial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
      end
    end
  end
`else
  logic w_unusedIsDiv;
  assign w_unusedIsDiv = i_isDiv;
  assign w_accNext     = {w_mulSum, r_acc[DATA_W-1:1]};
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_count <= '0;
      r_acc   <= '0;
      r_opB   <= '0;
`ifdef DATAPATH_SEQ_DIV_EN
      r_isDiv <= 1'b0;
`endif
    end else if (i_start) begin
      r_count <= ITER_N;
      r_acc   <= {{DATA_W{1'b0}}, i_opA};
      r_opB   <= i_opB;
`ifdef DATAPATH_SEQ_DIV_EN
      r_isDiv <= i_isDiv;
`endif
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
      r_acc   <= w_accNext;
    end
  end

  assign o_last = (r_count == CNT_W'(1));
  assign o_hi   = r_acc[2*DATA_W-1:DATA_W];
  assign o_lo   = r_acc[DATA_W-1:0];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: register file, Y/Z/HI/LO and a sequencer running one Ra <- Rb op Rc/imm per start.
// Define DATAPATH_SEQ_DIV_EN to make opcode 11 an unsigned restoring divide.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic           clock,
  input logic           clear_n,
  datapath_seq_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [SH_W:0] W_BITS = (SH_W + 1)'(DATA_W);

  state_t            r_state, w_nextState;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [4:0]        r_opcode;
  logic [SEL_W-1:0]  r_raSel, r_rbSel, r_rcSel;
  logic              r_useImm;
  logic [DATA_W-1:0] r_imm, r_y, r_z, r_hi, r_lo, r_result;
  logic              r_busy, r_done, r_err, r_errPend, r_illegal;
  logic              w_legal, w_isMulDiv, w_divZero, w_iterStart, w_iterLast;
  logic [DATA_W-1:0] w_opnd2, w_aluOut, w_iterHi, w_iterLo;
  logic [SH_W-1:0]   w_shamt;
  logic [SH_W:0]     w_rotBack;

  assign w_opnd2   = r_useImm ? r_imm : r_regs[r_rcSel];
  assign w_shamt   = w_opnd2[SH_W-1:0];
  assign w_rotBack = W_BITS - {1'b0, w_shamt};

`ifdef DATAPATH_SEQ_DIV_EN
  assign w_legal    = (r_opcode <= OP_DIV);
  assign w_isMulDiv = (r_opcode == OP_MUL) || (r_opcode == OP_DIV);
  assign w_divZero  = (r_opcode == OP_DIV) && (w_opnd2 == '0);
`else
  assign w_legal    = (r_opcode <= OP_MUL);
  assign w_isMulDiv = (r_opcode == OP_MUL);
  assign w_divZero  = 1'b0;
`endif

  // Rotate-left by zero shifts right by DATA_W, which yields zero and leaves Y unchanged.
  always_comb begin
    w_aluOut = '0;
    case (r_opcode)
      OP_ADD:  w_aluOut = r_y + w_opnd2;
      OP_SUB:  w_aluOut = r_y - w_opnd2;
      OP_AND:  w_aluOut = r_y & w_opnd2;
      OP_OR:   w_aluOut = r_y | w_opnd2;
      OP_SHL:  w_aluOut = r_y << w_shamt;
      OP_SHR:  w_aluOut = r_y >> w_shamt;
      OP_SHRA: w_aluOut = $signed(r_y) >>> w_shamt;
      OP_ROL:  w_aluOut = (r_y << w_shamt) | (r_y >> w_rotBack);
      OP_NEG:  w_aluOut = -r_y;
      OP_NOT:  w_aluOut = ~r_y;
      default: w_aluOut = '0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    w_iterStart = 1'b0;
    case (r_state)
      ST_IDLE:   if (bus.start) w_nextState = ST_LOAD_Y;
      ST_LOAD_Y: w_nextState = ST_EXEC;
      ST_EXEC: begin
        if (w_legal && w_isMulDiv) begin
          w_iterStart = 1'b1;
          w_nextState = ST_ITER;
        end else begin
          w_nextState = ST_WRITE;
        end
      end
      ST_ITER:   if (w_iterLast) w_nextState = ST_WRITE;
      ST_WRITE:  w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  iter_muldiv #(.DATA_W(DATA_W)) u_iter (
    .clock   (clock),
    .clear_n (clear_n),
    .i_start (w_iterStart),
    .i_isDiv (r_opcode == OP_DIV),
    .i_opA   (r_y),
    .i_opB   (w_opnd2),
    .o_last  (w_iterLast),
    .o_hi    (w_iterHi),
    .o_lo    (w_iterLo)
  );

  // The external load is scheduled first so an FSM write to the same register on this edge wins.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_opcode  <= '0;
      r_raSel   <= '0;
      r_rbSel   <= '0;
      r_rcSel   <= '0;
      r_useImm  <= 1'b0;
      r_imm     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_errPend <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bus.ext_wr_en && (bus.ext_wr_sel != '0)) r_regs[bus.ext_wr_sel] <= bus.ext_wr_data;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_opcode <= bus.opcode;
            r_raSel  <= bus.ra_sel;
            r_rbSel  <= bus.rb_sel;
            r_rcSel  <= bus.rc_sel;
            r_useImm <= bus.use_imm;
            r_imm    <= bus.imm;
            r_busy   <= 1'b1;
          end
        end
        ST_LOAD_Y: r_y <= r_regs[r_rbSel];
        ST_EXEC: begin
          r_illegal <= !w_legal;
          r_errPend <= !w_legal || w_divZero;
          if (w_legal && !w_isMulDiv) r_z <= w_aluOut;
        end
        ST_WRITE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_err  <= r_errPend;
          if (!r_illegal) begin
            if (w_isMulDiv) begin
              r_hi     <= w_iterHi;
              r_lo     <= w_iterLo;
              r_result <= w_iterLo;
            end else begin
              if (r_raSel != '0) r_regs[r_raSel] <= r_z;
              r_result <= r_z;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dbg_rd_data = r_regs[bus.dbg_rd_sel];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.result      = r_result;
  assign bus.hi_out      = r_hi;
  assign bus.lo_out      = r_lo;
endmodule
